// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EXE/MS/WB/dcache signal bundle for the memory pipeline stage
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_load_op;
    logic        es_store_op;
    logic [1:0]  es_mem_size;
    logic        es_mem_sign;
    logic        es_excp;
    logic        es_ertn;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        excp_flush;
    logic        ertn_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_excp;
    logic        ms_flush;
    logic        ms_fwd_valid;
    logic        ms_fwd_stall;
    logic [31:0] ms_fwd_data;

    modport slave (
        input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op,
               es_store_op, es_mem_size, es_mem_sign, es_excp, es_ertn,
               data_data_ok, data_rdata, excp_flush, ertn_flush, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest,
               ms_gr_we, ms_excp, ms_flush, ms_fwd_valid, ms_fwd_stall, ms_fwd_data
    );

    modport master (
        output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_load_op,
               es_store_op, es_mem_size, es_mem_sign, es_excp, es_ertn,
               data_data_ok, data_rdata, excp_flush, ertn_flush, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest,
               ms_gr_we, ms_excp, ms_flush, ms_fwd_valid, ms_fwd_stall, ms_fwd_data
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: dcache response wait, load extract, flush drop
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;

    logic [1:0]          state;
    logic [CANCEL_W-1:0] cancel_cnt;
    logic [31:0]         rdata_buf;
    logic [31:0]         pc_r;
    logic [31:0]         result_r;
    logic [4:0]          dest_r;
    logic                gr_we_r;
    logic                load_r;
    logic [1:0]          size_r;
    logic                sign_r;
    logic                excp_r;
    logic                ertn_r;

    logic ms_valid;
    logic req;
    logic flush;
    logic live_ok;
    logic ready_go;
    logic allowin;
    logic accept;
    logic leave;
    logic cancel_inc;
    logic cancel_dec;

    assign ms_valid   = (state != S_IDLE);
    assign req        = (bus.es_load_op | bus.es_store_op) & ~bus.es_excp;
    assign flush      = bus.excp_flush | bus.ertn_flush;
    // A response only belongs to the current entry once all flushed ones are drained.
    assign live_ok    = (state == S_WAIT) & bus.data_data_ok & (cancel_cnt == '0);
    assign ready_go   = (state == S_DONE) | live_ok;
    assign allowin    = ~ms_valid | (ready_go & bus.ws_allowin);
    assign accept     = bus.es_to_ms_valid & allowin & ~flush;
    assign leave      = ms_valid & ready_go & bus.ws_allowin;
    assign cancel_inc = flush & (state == S_WAIT) & ~live_ok;
    assign cancel_dec = bus.data_data_ok & (cancel_cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cancel_cnt <= '0;
            rdata_buf  <= '0;
            pc_r       <= '0;
            result_r   <= '0;
            dest_r     <= '0;
            gr_we_r    <= 1'b0;
            load_r     <= 1'b0;
            size_r     <= '0;
            sign_r     <= 1'b0;
            excp_r     <= 1'b0;
            ertn_r     <= 1'b0;
        end else begin
            if (flush)
                state <= S_IDLE;
            else if (accept)
                state <= req ? S_WAIT : S_DONE;
            else if (leave)
                state <= S_IDLE;
            else if (live_ok)
                state <= S_DONE;

            if (live_ok && !bus.ws_allowin)
                rdata_buf <= bus.data_rdata;

            if (accept) begin
                pc_r     <= bus.es_pc;
                result_r <= bus.es_result;
                dest_r   <= bus.es_dest;
                gr_we_r  <= bus.es_gr_we;
                load_r   <= bus.es_load_op;
                size_r   <= bus.es_mem_size;
                sign_r   <= bus.es_mem_sign;
                excp_r   <= bus.es_excp;
                ertn_r   <= bus.es_ertn;
            end

            if (cancel_inc && !cancel_dec && cancel_cnt != CANCEL_MAX)
                cancel_cnt <= cancel_cnt + 1'b1;
            else if (cancel_dec && !cancel_inc)
                cancel_cnt <= cancel_cnt - 1'b1;
        end
    end

    logic [31:0] rdata_src;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val;
    logic [31:0] final_result;

    // In WAIT the data comes straight from the dcache; in DONE from the holding buffer.
    assign rdata_src = (state == S_WAIT) ? bus.data_rdata : rdata_buf;
    assign byte_v    = rdata_src[{result_r[1:0], 3'b000} +: 8];
    assign half_v    = rdata_src[{result_r[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rdata_src;
        if (size_r[0])
            load_val = {{24{sign_r & byte_v[7]}}, byte_v};
        else if (size_r[1])
            load_val = {{16{sign_r & half_v[15]}}, half_v};
    end

    assign final_result = (load_r & ~excp_r) ? load_val : result_r;

    assign bus.ms_allowin      = allowin;
    assign bus.ms_to_ws_valid  = ms_valid & ready_go;
    assign bus.ms_pc           = pc_r;
    assign bus.ms_final_result = final_result;
    assign bus.ms_dest         = dest_r;
    assign bus.ms_gr_we        = gr_we_r & ~excp_r;
    assign bus.ms_excp         = excp_r;
    assign bus.ms_flush        = ms_valid & (excp_r | ertn_r);
    assign bus.ms_fwd_valid    = ms_valid & gr_we_r & (dest_r != 5'd0) & ~excp_r;
    assign bus.ms_fwd_stall    = bus.ms_fwd_valid & (state == S_WAIT) & load_r;
    assign bus.ms_fwd_data     = final_result;

    a_cancel_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(cancel_inc && !cancel_dec && cancel_cnt == CANCEL_MAX));

    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!reset)
        (bus.data_data_ok && cancel_cnt == '0) |-> (state == S_WAIT));
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: directed, table and random vs model
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_if bus();
    mem_stage #(.CANCEL_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[9];

    // reference model state: one instruction slot and an in-order dcache response queue
    bit          m_valid, m_wait;
    logic [31:0] m_pc, m_res, m_data;
    logic [4:0]  m_dest;
    logic        m_we, m_ld, m_ex, m_ertn, m_sg;
    logic [1:0]  m_sz;
    bit          dc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.es_to_ms_valid = 0; bus.es_pc = 0; bus.es_result = 0; bus.es_dest = 0;
        bus.es_gr_we = 0; bus.es_load_op = 0; bus.es_store_op = 0; bus.es_mem_size = 0;
        bus.es_mem_sign = 0; bus.es_excp = 0; bus.es_ertn = 0; bus.data_data_ok = 0;
        bus.data_rdata = 0; bus.excp_flush = 0; bus.ertn_flush = 0; bus.ws_allowin = 1;
    endtask

    task automatic offer(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] res, input logic [4:0] dst, input logic we,
                         input logic ex);
        bus.es_to_ms_valid = 1; bus.es_pc = $urandom; bus.es_load_op = ld; bus.es_store_op = st;
        bus.es_mem_size = sz; bus.es_mem_sign = sg; bus.es_result = res; bus.es_dest = dst;
        bus.es_gr_we = we; bus.es_excp = ex; bus.es_ertn = 0;
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] addr, input logic [31:0] d);
        int unsigned v;
        int unsigned w;
        w = sz[0] ? 8 : (sz[1] ? 16 : 32);
        if (w == 32) return d;
        if (w == 8) v = (d >> (8 * (addr % 4))) & 32'hFF;
        else        v = (d >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        if (sg && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
        return v;
    endfunction

    initial begin
        int handoffs;
        bit resp_live, ready, exp_allow, accept, flush_now, live, fv;
        int unsigned s;

        tbl[0] = '{2'b01, 1'b1, 32'h0000_0100, 32'h1234_567F, 32'h0000_007F};
        tbl[1] = '{2'b01, 1'b1, 32'h0000_0101, 32'h0000_8000, 32'hFFFF_FF80};
        tbl[2] = '{2'b01, 1'b0, 32'h0000_0102, 32'h00AB_0000, 32'h0000_00AB};
        tbl[3] = '{2'b01, 1'b0, 32'h0000_0103, 32'hC000_0000, 32'h0000_00C0};
        tbl[4] = '{2'b10, 1'b1, 32'h0000_0200, 32'h1234_8001, 32'hFFFF_8001};
        tbl[5] = '{2'b10, 1'b1, 32'h0000_0202, 32'h7FFF_0000, 32'h0000_7FFF};
        tbl[6] = '{2'b10, 1'b0, 32'h0000_0202, 32'h8000_0000, 32'h0000_8000};
        tbl[7] = '{2'b00, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[8] = '{2'b01, 1'b1, 32'h0000_0100, 32'hFFFF_FF7F, 32'h0000_007F};

        idle_in();
        reset = 0;
        tick(); tick();
        chk("rst_to_ws", bus.ms_to_ws_valid, 0);
        chk("rst_allowin", bus.ms_allowin, 1);
        chk("rst_flush", bus.ms_flush, 0);
        chk("rst_fwd_valid", bus.ms_fwd_valid, 0);
        chk("rst_fwd_stall", bus.ms_fwd_stall, 0);
        chk("rst_fwd_data", bus.ms_fwd_data, 0);
        reset = 1;
        tick();

        // 1: ld.b sign-extended, data_ok two cycles after accept
        offer(1, 0, 2'b01, 1, 32'h1003, 5'd3, 1, 0);
        #1 chk("t1_allowin", bus.ms_allowin, 1);
        tick(); bus.es_to_ms_valid = 0;
        #1 chk("t1_wait_to_ws", bus.ms_to_ws_valid, 0);
        tick(); bus.data_data_ok = 1; bus.data_rdata = 32'h80FF_FFFF;
        #1 chk("t1_to_ws", bus.ms_to_ws_valid, 1);
        chk("t1_result", bus.ms_final_result, 32'hFFFF_FF80);
        tick(); bus.data_data_ok = 0;
        #1 chk("t1_gone", bus.ms_to_ws_valid, 0);

        // 2: ld.hu held in DONE while WB stalls
        offer(1, 0, 2'b10, 0, 32'h2002, 5'd4, 1, 0);
        tick(); bus.es_to_ms_valid = 0;
        tick();
        handoffs = 0;
        for (int k = 0; k < 4; k++) begin
            bus.data_data_ok = (k == 0); bus.data_rdata = (k == 0) ? 32'hBEEF_1234 : 32'h0;
            bus.ws_allowin = (k == 3);
            #1 chk("t2_to_ws", bus.ms_to_ws_valid, 1);
            chk("t2_result", bus.ms_final_result, 32'h0000_BEEF);
            if (bus.ms_to_ws_valid && bus.ws_allowin) handoffs++;
            tick();
        end
        bus.data_data_ok = 0;
        #1 chk("t2_gone", bus.ms_to_ws_valid, 0);
        chk("t2_handoffs", handoffs, 1);

        // 3: flushed pending load; its response must be dropped
        offer(1, 0, 2'b00, 0, 32'h3000, 5'd5, 1, 0);
        tick(); bus.es_to_ms_valid = 0; bus.excp_flush = 1;
        tick(); bus.excp_flush = 0;
        #1 chk("t3_flushed", bus.ms_to_ws_valid, 0);
        chk("t3_allowin", bus.ms_allowin, 1);
        offer(1, 0, 2'b00, 0, 32'h3004, 5'd5, 1, 0);
        tick(); bus.es_to_ms_valid = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h1111_1111;
        #1 chk("t3_drop", bus.ms_to_ws_valid, 0);
        tick(); bus.data_rdata = 32'h2222_2222;
        #1 chk("t3_to_ws", bus.ms_to_ws_valid, 1);
        chk("t3_result", bus.ms_final_result, 32'h2222_2222);
        tick(); bus.data_data_ok = 0;
        offer(1, 0, 2'b00, 0, 32'h3008, 5'd5, 1, 0);
        tick(); bus.es_to_ms_valid = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h3333_3333;
        #1 chk("t3_cnt_zero", bus.ms_to_ws_valid, 1);
        tick(); bus.data_data_ok = 0;

        // 4: back-to-back ALU instructions
        for (int i = 0; i < 4; i++) begin
            if (i < 3) offer(0, 0, 2'b00, 0, 32'h5, 5'd4, 1, 0);
            else bus.es_to_ms_valid = 0;
            #1 chk("t4_allowin", bus.ms_allowin, 1);
            if (i > 0) begin
                chk("t4_to_ws", bus.ms_to_ws_valid, 1);
                chk("t4_fwd_valid", bus.ms_fwd_valid, 1);
                chk("t4_fwd_stall", bus.ms_fwd_stall, 0);
                chk("t4_fwd_data", bus.ms_fwd_data, 32'h5);
            end
            tick();
        end

        // 5: load-use stall, then an excepting instruction
        offer(1, 0, 2'b00, 0, 32'h40, 5'd7, 1, 0);
        tick(); bus.es_to_ms_valid = 0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t5_stall", bus.ms_fwd_stall, 1);
            chk("t5_wait", bus.ms_to_ws_valid, 0);
            tick();
        end
        bus.data_data_ok = 1; bus.data_rdata = 32'h0000_0077;
        #1 chk("t5_to_ws", bus.ms_to_ws_valid, 1);
        tick(); bus.data_data_ok = 0;
        offer(1, 0, 2'b00, 0, 32'h44, 5'd3, 1, 1);
        tick(); bus.es_to_ms_valid = 0;
        #1 chk("t5_ms_flush", bus.ms_flush, 1);
        chk("t5_gr_we", bus.ms_gr_we, 0);
        chk("t5_excp", bus.ms_excp, 1);
        chk("t5_done", bus.ms_to_ws_valid, 1);
        chk("t5_fwd_valid", bus.ms_fwd_valid, 0);
        tick();

        // table: load extraction cases
        for (int i = 0; i < 9; i++) begin
            offer(1, 0, tbl[i].sz, tbl[i].sg, tbl[i].addr, 5'd1, 1, 0);
            tick(); bus.es_to_ms_valid = 0; bus.data_data_ok = 1; bus.data_rdata = tbl[i].rd;
            #1 chk($sformatf("tbl%0d_to_ws", i), bus.ms_to_ws_valid, 1);
            chk($sformatf("tbl%0d_result", i), bus.ms_final_result, tbl[i].exp);
            tick(); bus.data_data_ok = 0;
        end

        // 6: asynchronous reset mid-WAIT
        offer(1, 0, 2'b00, 0, 32'h80, 5'd6, 1, 0);
        tick(); bus.es_to_ms_valid = 0;
        #1 chk("t6_wait", bus.ms_to_ws_valid, 0);
        #1 reset = 0;
        #1 chk("t6_to_ws", bus.ms_to_ws_valid, 0);
        chk("t6_allowin", bus.ms_allowin, 1);
        chk("t6_fwd_valid", bus.ms_fwd_valid, 0);
        chk("t6_fwd_stall", bus.ms_fwd_stall, 0);
        chk("t6_result", bus.ms_final_result, 0);
        chk("t6_pc", bus.ms_pc, 0);
        tick(); reset = 1;
        offer(0, 0, 2'b00, 0, 32'h9, 5'd2, 1, 0);
        tick(); bus.es_to_ms_valid = 0;
        #1 chk("t6_after_to_ws", bus.ms_to_ws_valid, 1);
        chk("t6_after_result", bus.ms_final_result, 32'h9);
        tick();

        // randomized traffic against the transaction-level model
        m_valid = 0; m_wait = 0; m_data = 0; dc_q.delete();
        for (int c = 0; c < 400; c++) begin
            bus.ws_allowin   = ($urandom_range(0, 3) != 0);
            bus.data_data_ok = (dc_q.size() > 0) && ($urandom_range(0, 2) != 0);
            bus.data_rdata   = $urandom;
            flush_now        = (dc_q.size() < 3) && ($urandom_range(0, 11) == 0);
            s = $urandom_range(0, 1);
            bus.excp_flush   = flush_now && (s == 0);
            bus.ertn_flush   = flush_now && (s == 1);
            bus.es_to_ms_valid = $urandom_range(0, 1);
            s = $urandom_range(0, 2);
            bus.es_load_op   = (s == 0);
            bus.es_store_op  = (s == 1);
            s = $urandom_range(0, 2);
            bus.es_mem_size  = (s == 0) ? 2'b00 : ((s == 1) ? 2'b01 : 2'b10);
            bus.es_mem_sign  = $urandom_range(0, 1);
            bus.es_result    = $urandom;
            bus.es_pc        = $urandom;
            bus.es_dest      = $urandom_range(0, 31);
            bus.es_gr_we     = $urandom_range(0, 1);
            bus.es_excp      = ($urandom_range(0, 9) == 0);
            bus.es_ertn      = !bus.es_excp && ($urandom_range(0, 15) == 0);
            #1;
            resp_live = bus.data_data_ok && dc_q[0];
            ready     = m_valid && (!m_wait || resp_live);
            exp_allow = !m_valid || (ready && bus.ws_allowin);
            fv        = m_valid && m_we && (m_dest != 0) && !m_ex;
            chk("rnd_to_ws", bus.ms_to_ws_valid, ready);
            chk("rnd_allowin", bus.ms_allowin, exp_allow);
            chk("rnd_ms_flush", bus.ms_flush, m_valid && (m_ex || m_ertn));
            chk("rnd_fwd_valid", bus.ms_fwd_valid, fv);
            chk("rnd_fwd_stall", bus.ms_fwd_stall, fv && m_wait && m_ld);
            if (ready) begin
                chk("rnd_result", bus.ms_final_result, (m_ld && !m_ex) ?
                    ref_load(m_sz, m_sg, m_res, m_wait ? bus.data_rdata : m_data) : m_res);
                chk("rnd_pc", bus.ms_pc, m_pc);
                chk("rnd_dest", bus.ms_dest, m_dest);
                chk("rnd_gr_we", bus.ms_gr_we, m_we && !m_ex);
            end
            accept = bus.es_to_ms_valid && exp_allow && !flush_now;
            if (bus.data_data_ok) begin
                live = dc_q.pop_front();
                if (live) begin m_wait = 0; m_data = bus.data_rdata; end
            end
            if (flush_now) begin
                if (m_valid && m_wait) dc_q[dc_q.size() - 1] = 0;
                m_valid = 0; m_wait = 0;
            end else if (accept) begin
                m_valid = 1; m_pc = bus.es_pc; m_res = bus.es_result; m_dest = bus.es_dest;
                m_we = bus.es_gr_we; m_ld = bus.es_load_op; m_ex = bus.es_excp;
                m_ertn = bus.es_ertn; m_sg = bus.es_mem_sign; m_sz = bus.es_mem_size;
                m_wait = (bus.es_load_op || bus.es_store_op) && !bus.es_excp;
                if (m_wait) dc_q.push_back(1);
            end else if (ready && bus.ws_allowin) begin
                m_valid = 0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
